// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the mem_loader job sequencer.
package mem_loader_pkg;

    localparam int CYC_W = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ABORT = 3'd4
    } state_t;

endpackage

// File: rtl/mem_loader_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    // Count enabled cycles, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX)) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_loader.sv
// Host-side job sequencer: load image, run core, drain result window.
// Optional build macro MEM_LOADER_CHECKSUM_EN appends an XOR checksum beat to the drain.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int AW       = 8,
    parameter int LOAD_LEN = 64,
    parameter int RES_BASE = 64,
    parameter int RES_LEN  = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             core_req,
    input  logic             core_done,
    output logic             mem_own,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    output logic             busy,
    output logic             timeout,
    output logic [CYC_W-1:0] cycles
);

    // Two spare bits so a full 2^AW load, or RES_LEN plus a checksum beat, fits.
    localparam int CW = AW + 2;
    localparam logic [CW-1:0]    LOAD_LAST = CW'(LOAD_LEN - 1);
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam logic [CW-1:0]    DRAIN_LAST = CW'(RES_LEN);
`else
    localparam logic [CW-1:0]    DRAIN_LAST = CW'(RES_LEN - 1);
`endif
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(TIMEOUT - 1);
    localparam logic [AW-1:0]    ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    BEAT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [AW-1:0]    r_addr;
    logic [CW-1:0]    r_beat;
    logic             r_timeout;
    logic             w_load_hs;
    logic             w_drain_hs;
    logic             w_cyc_clr;
    logic             w_cyc_en;
    logic [CYC_W-1:0] w_cycles;

    assign w_load_hs  = (r_state == S_LOAD) && s_valid;
    assign w_drain_hs = (r_state == S_DRAIN) && m_ready;
    assign w_cyc_clr  = w_load_hs && (r_beat == LOAD_LAST);
    assign w_cyc_en   = (r_state == S_RUN);

    sat_counter #(
        .W (CYC_W)
    ) u_cycles (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_cyc_clr),
        .i_en    (w_cyc_en),
        .o_count (w_cycles)
    );

    // Job sequencing FSM with address, beat and sticky-timeout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_beat    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_timeout <= 1'b0;
                        r_addr    <= '0;
                        r_beat    <= '0;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        r_addr <= r_addr + ADDR_ONE;
                        if (r_beat == LOAD_LAST) begin
                            r_beat  <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_beat <= r_beat + BEAT_ONE;
                        end
                    end
                end
                S_RUN: begin
                    // core_done takes precedence over an expiring timeout.
                    if (core_done) begin
                        r_addr  <= AW'(RES_BASE);
                        r_beat  <= '0;
                        r_state <= S_DRAIN;
                    end else if (w_cycles == CYC_LIMIT) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_ABORT;
                    end
                end
                S_DRAIN: begin
                    if (m_ready) begin
                        r_addr <= r_addr + ADDR_ONE;
                        if (r_beat == DRAIN_LAST) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + BEAT_ONE;
                        end
                    end
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    byte_t r_csum;

    // XOR of accepted data beats; the final beat presents it instead of memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= 8'h00;
        end else if ((r_state == S_RUN) && core_done) begin
            r_csum <= 8'h00;
        end else if (w_drain_hs && (r_beat != DRAIN_LAST)) begin
            r_csum <= r_csum ^ mem_rdata;
        end else begin
            r_csum <= r_csum;
        end
    end

    assign m_data = (r_state != S_DRAIN) ? 8'h00 :
                    (r_beat == DRAIN_LAST) ? r_csum : mem_rdata;
`else
    assign m_data = (r_state == S_DRAIN) ? mem_rdata : 8'h00;
`endif

    assign busy      = (r_state != S_IDLE);
    assign s_ready   = (r_state == S_LOAD);
    assign m_valid   = (r_state == S_DRAIN);
    assign m_last    = (r_state == S_DRAIN) && (r_beat == DRAIN_LAST);
    assign core_req  = (r_state == S_RUN);
    assign mem_own   = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign mem_wr_en = w_load_hs;
    assign mem_addr  = r_addr;
    assign mem_wdata = w_load_hs ? s_data : 8'h00;
    assign timeout   = r_timeout;
    assign cycles    = w_cycles;

endmodule
